// File: rtl/sc_bit_decision_psum.sv
// Leaf stage of an SC polar decoder: frozen-masked hard decisions, per-frame bit store, g-node partial sums.
// Optional frozen-bit disagreement flag (frz_err) is built only when FROZEN_CHECK_EN is defined.
module sc_bit_decision_psum #(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int LLRW  = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     frozen,
  input  logic             llr_valid,
  input  logic [LLRW-1:0]  llr_in,
  output logic [LOG2N-1:0] bit_idx,
  output logic             busy,
  input  logic [LOG2N-1:0] q_stage,
  input  logic [LOG2N-1:0] q_idx,
  output logic             u_sum,
  output logic [N-1:0]     u_hat,
  output logic             done,
  output logic             frz_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   N_EXT    = (LOG2N + 1)'(N);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   mask;
  logic           llr_neg;
  logic           take;
  logic           dec_bit;

  // LLR == 0 is not negative, so it decides 0 like any non-negative value.
  assign llr_neg = $signed(llr_in) < $signed({LLRW{1'b0}});
  assign take    = (state == S_DEC) && llr_valid && !start;
  assign dec_bit = ~mask[bit_idx] & llr_neg;

  assign busy = (state == S_DEC);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_DEC;
    end else begin
      case (state)
        S_DEC:   if (llr_valid && (bit_idx == LAST_IDX)) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // bit_idx is exactly LOG2N wide, so the increment past N-1 wraps to 0 on the way into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      u_hat   <= '0;
      mask    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        mask    <= frozen;
        u_hat   <= '0;
        bit_idx <= '0;
      end else if (take) begin
        u_hat[bit_idx] <= dec_bit;
        bit_idx        <= bit_idx + LOG2N'(1);
      end
    end
  end

  logic [LOG2N:0]   half_len;
  logic [LOG2N-1:0] blk_mask;
  logic [LOG2N-1:0] base;

  assign half_len = (LOG2N + 1)'(1) << q_stage;
  assign blk_mask = (half_len[LOG2N-1:0] - LOG2N'(1)) | half_len[LOG2N-1:0];
  assign base     = bit_idx & ~blk_mask;

  logic             acc;
  logic [LOG2N-1:0] kk;
  logic [LOG2N:0]   idx;

  // x[j] of the left sibling block: XOR of every u[base+k] whose k is a bitwise superset of j.
  always_comb begin
    acc = 1'b0;
    kk  = '0;
    idx = '0;
    for (int k = 0; k < N / 2; k++) begin
      kk  = LOG2N'(k);
      idx = {1'b0, base} + {1'b0, kk};
      if (((LOG2N + 1)'(k) < half_len) && ((q_idx & ~kk) == '0) && (idx < N_EXT)) begin
        acc = acc ^ u_hat[idx[LOG2N-1:0]];
      end
    end
  end

  assign u_sum = acc;

`ifdef FROZEN_CHECK_EN
  logic frz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frz_q <= 1'b0;
    end else if (start) begin
      frz_q <= 1'b0;
    end else if (take && mask[bit_idx] && llr_neg) begin
      frz_q <= 1'b1;
    end
  end

  assign frz_err = frz_q;
`else
  assign frz_err = 1'b0;
`endif

endmodule

// File: tb/tb_sc_bit_decision_psum.sv
// Bench for sc_bit_decision_psum at N=8: frame-level model plus per-cycle compare and directed literal checks.
module tb_sc_bit_decision_psum;

  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam int LLRW = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [N-1:0]     frozen;
  logic             llr_valid;
  logic [LLRW-1:0]  llr_in;
  logic [LOG2N-1:0] bit_idx;
  logic             busy;
  logic [LOG2N-1:0] q_stage;
  logic [LOG2N-1:0] q_idx;
  logic             u_sum;
  logic [N-1:0]     u_hat;
  logic             done;
  logic             frz_err;

  int total = 0;
  int bad = 0;
  bit q_manual = 1'b0;

  sc_bit_decision_psum #(.N(N), .LOG2N(LOG2N), .LLRW(LLRW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frozen(frozen),
    .llr_valid(llr_valid), .llr_in(llr_in), .bit_idx(bit_idx), .busy(busy),
    .q_stage(q_stage), .q_idx(q_idx), .u_sum(u_sum), .u_hat(u_hat),
    .done(done), .frz_err(frz_err)
  );

  always #5 clk = ~clk;

  // Frame-level model of what the decoder has decided so far.
  bit           m_active = 1'b0;
  int           m_pos = 0;
  logic [N-1:0] m_bits = '0;
  logic [N-1:0] m_mask = '0;
  bit           m_done = 1'b0;
  bit           m_frz = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_pos = 0; m_bits = '0; m_mask = '0; m_done = 1'b0; m_frz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1; m_pos = 0; m_bits = '0; m_mask = frozen; m_frz = 1'b0;
      end else if (m_active && llr_valid) begin
        if (m_mask[m_pos]) begin
          if ($signed(llr_in) < 0) m_frz = 1'b1;
        end else begin
          m_bits[m_pos] = ($signed(llr_in) < 0);
        end
        if (m_pos == N - 1) begin
          m_active = 1'b0; m_pos = 0; m_done = 1'b1;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
  end

  // Polar transform of the left sibling block via in-place butterflies.
  function automatic logic exp_usum(input logic [N-1:0] bits, input int pos, input int s, input int j);
    logic x[N];
    int len;
    int b;
    len = 1 << s;
    b = (pos / (2 * len)) * (2 * len);
    for (int k = 0; k < N; k++) x[k] = 1'b0;
    for (int k = 0; k < len; k++) x[k] = bits[b + k];
    for (int h = 1; h < len; h = h * 2)
      for (int i = 0; i < len; i++)
        if ((i & h) == 0) x[i] = x[i] ^ x[i + h];
    return x[j];
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    int exp_frz;
    @(posedge clk);
    #2;
`ifdef FROZEN_CHECK_EN
    exp_frz = int'(m_frz);
`else
    exp_frz = 0;
`endif
    chk("u_hat", int'(u_hat), int'(m_bits));
    chk("bit_idx", int'(bit_idx), m_pos);
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
    chk("frz_err", int'(frz_err), exp_frz);
    if (m_active && (int'(q_stage) < LOG2N) && (int'(q_idx) < (1 << q_stage)))
      chk("u_sum", int'(u_sum), int'(exp_usum(m_bits, m_pos, int'(q_stage), int'(q_idx))));
  end

  // Sweeps every legal (stage, index) query pair unless a directed test owns the query ports.
  initial begin
    int p = 0;
    q_stage = '0;
    q_idx = '0;
    forever begin
      @(negedge clk);
      if (!q_manual) begin
        if (p == 0) begin q_stage = 3'd0; q_idx = 3'd0; end
        else if (p < 3) begin q_stage = 3'd1; q_idx = 3'(p - 1); end
        else begin q_stage = 3'd2; q_idx = 3'(p - 3); end
        p = (p + 1) % 7;
      end
    end
  end

  task automatic cyc(input logic s, input logic v, input int l);
    @(negedge clk);
    start = s;
    llr_valid = v;
    llr_in = 17'(l);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  int llr2[8] = '{-5, -3, 2, -1, -9, 4, -7, -2};

  initial begin
    rst_n = 1'b0; start = 1'b0; frozen = '0; llr_valid = 1'b0; llr_in = '0;
    settle();
    chk("reset u_hat", int'(u_hat), 0);
    chk("reset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // llr_valid in IDLE is ignored
    cyc(0, 1, -6);
    settle();
    chk("idle u_hat", int'(u_hat), 0);
    chk("idle bit_idx", int'(bit_idx), 0);

    // Reset mid-frame
    frozen = 8'h00;
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, -1);
    settle();
    chk("mid u_hat", int'(u_hat), 8'h1F);
    chk("mid bit_idx", int'(bit_idx), 5);
    @(negedge clk);
    start = 1'b0; llr_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    chk("rst u_hat", int'(u_hat), 0);
    chk("rst bit_idx", int'(bit_idx), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frozen-mask decisions
    frozen = 8'h17;
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, llr2[i]);
    settle();
    chk("t2 done", int'(done), 1);
    chk("t2 busy", int'(busy), 0);
    chk("t2 u_hat", int'(u_hat), 8'hC8);
    cyc(0, 0, 0);
    settle();
    chk("t2 done drop", int'(done), 0);
    chk("t2 u_hat hold", int'(u_hat), 8'hC8);

    // Partial sums
    frozen = 8'h00;
    q_manual = 1'b1;
    cyc(1, 0, 0);
    cyc(0, 1, -1);
    cyc(0, 1, -1);
    cyc(0, 0, 0);
    q_stage = 3'd1; q_idx = 3'd0;
    settle();
    chk("t3 s1j0", int'(u_sum), 0);
    cyc(0, 0, 0);
    q_stage = 3'd1; q_idx = 3'd1;
    settle();
    chk("t3 s1j1", int'(u_sum), 1);
    cyc(0, 0, 0);
    q_stage = 3'd0; q_idx = 3'd0;
    settle();
    chk("t3 s0j0", int'(u_sum), 0);
    chk("t3 bit_idx", int'(bit_idx), 2);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    q_stage = 3'd2; q_idx = 3'd1;
    settle();
    chk("t3 s2j1", int'(u_sum), 1);
    cyc(0, 0, 0);
    q_stage = 3'd2; q_idx = 3'd0;
    settle();
    chk("t3 s2j0", int'(u_sum), 0);
    q_manual = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 1, -1);
    settle();
    chk("t3 u_hat", int'(u_hat), 8'hF3);

    // Restart mid-frame with a colliding LLR
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, -1);
    cyc(1, 1, -1);
    settle();
    chk("t4 bit_idx", int'(bit_idx), 0);
    chk("t4 u_hat", int'(u_hat), 0);
    chk("t4 busy", int'(busy), 1);
    chk("t4 done", int'(done), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, (i % 2 == 0) ? 3 : -3);
    settle();
    chk("t4 u_hat end", int'(u_hat), 8'hAA);

    // llr_valid during DONE and IDLE
    cyc(0, 1, -8);
    settle();
    chk("t5 done-cyc u_hat", int'(u_hat), 8'hAA);
    cyc(0, 1, -8);
    settle();
    chk("t5 idle u_hat", int'(u_hat), 8'hAA);
    chk("t5 idle bit_idx", int'(bit_idx), 0);

    // Frozen-bit disagreement flag
    frozen = 8'h01;
    cyc(1, 0, 0);
    cyc(0, 1, -4);
    settle();
`ifdef FROZEN_CHECK_EN
    chk("t6 frz set", int'(frz_err), 1);
`else
    chk("t6 frz tied", int'(frz_err), 0);
`endif
    for (int i = 0; i < 7; i++) cyc(0, 1, 1);
    cyc(0, 0, 0);
    settle();
`ifdef FROZEN_CHECK_EN
    chk("t6 frz hold", int'(frz_err), 1);
`else
    chk("t6 frz hold tied", int'(frz_err), 0);
`endif
    chk("t6 u_hat", int'(u_hat), 0);
    cyc(1, 0, 0);
    settle();
    chk("t6 frz clear", int'(frz_err), 0);
    cyc(0, 0, 0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
